// File: rtl/bit4_sum_accumulator.sv
// Sums a stream of 5-bit ripple-carry adder results ({carry, sum}) into an ACC_W-bit total,
// presenting the total and a sticky overflow flag on a valid/ready port after every N_BEATS beats.
module bit4_sum_accumulator #(
  parameter int ACC_W   = 8,
  parameter int N_BEATS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int PAD_W = ACC_W - 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [ACC_W:0]   addend;
  logic [ACC_W:0]   sum_wide;

  // Bit ACC_W of the widened sum is the carry out of the accumulator.
  assign addend   = {{PAD_W{1'b0}}, in_carry, in_sum};
  assign sum_wide = {1'b0, acc_reg} + addend;

  assign in_ready  = (state_reg == ACCUM) && !clear;
  assign out_valid = (state_reg == DONE);
  assign out_acc   = acc_reg;
  assign out_ovf   = ovf_reg;
  assign beat_cnt  = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      // Abort wins over both beat acceptance and the output handshake.
      state_next = ACCUM;
      acc_next   = '0;
      ovf_next   = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            acc_next = sum_wide[ACC_W-1:0];
            ovf_next = ovf_reg | sum_wide[ACC_W];
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_BEAT) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = ACCUM;
            acc_next   = '0;
            ovf_next   = 1'b0;
            cnt_next   = '0;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_bit4_sum_accumulator.sv
// Directed bench: a default-parameter instance and an ACC_W=6 instance for the overflow case,
// with expected results queued at stimulus time and popped by a handshake monitor.
module tb_bit4_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       in_valid, in_carry, out_ready;
  logic [3:0] in_sum;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_acc, beat_cnt;

  logic       b_in_valid, b_in_carry, b_out_ready;
  logic [3:0] b_in_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [5:0] b_out_acc;
  logic [7:0] b_beat_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_a[$];
  logic [6:0] exp_b[$];

  always #5 clk = ~clk;

  bit4_sum_accumulator #(.ACC_W(8), .N_BEATS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
    .beat_cnt(beat_cnt)
  );

  bit4_sum_accumulator #(.ACC_W(6), .N_BEATS(4), .CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .in_carry(b_in_carry),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf),
    .beat_cnt(b_beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic c, input logic [3:0] s);
    in_valid = 1'b1; in_carry = c; in_sum = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_b(input logic c, input logic [3:0] s);
    b_in_valid = 1'b1; b_in_carry = c; b_in_sum = s;
    tick();
    b_in_valid = 1'b0;
  endtask

  // Monitor: a result is consumed on a valid&ready cycle that is not cancelled by clear/rst.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_result", 32'(out_acc), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = exp_a.pop_front();
        check("a_out_acc", 32'(out_acc), 32'(e[7:0]));
        check("a_out_ovf", 32'(out_ovf), 32'(e[8]));
        check("a_beat_cnt_at_pop", 32'(beat_cnt), 32'd4);
      end
    end
    if (!rst && !clear && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_result", 32'(b_out_acc), 32'hFFFF_FFFF);
      end else begin
        logic [6:0] e;
        e = exp_b.pop_front();
        check("b_out_acc", 32'(b_out_acc), 32'(e[5:0]));
        check("b_out_ovf", 32'(b_out_ovf), 32'(e[6]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_carry = 1'b0; in_sum = 4'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_carry = 1'b0; b_in_sum = 4'd0; b_out_ready = 1'b0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_beat_cnt", 32'(beat_cnt), 32'd0);
    check("reset_out_acc", 32'(out_acc), 32'd0);
    check("reset_out_ovf", 32'(out_ovf), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic sum: 3 + 5 + 16 + 15 = 39
    out_ready = 1'b1;
    exp_a.push_back({1'b0, 8'h27});
    send(1'b0, 4'd3);
    send(1'b0, 4'd5);
    send(1'b1, 4'd0);
    check("basic_not_valid_before_last", 32'(out_valid), 32'd0);
    send(1'b0, 4'd15);
    check("basic_valid_after_last", 32'(out_valid), 32'd1);
    check("basic_in_ready_done", 32'(in_ready), 32'd0);
    tick();
    check("basic_rearm_in_ready", 32'(in_ready), 32'd1);
    check("basic_rearm_beat_cnt", 32'(beat_cnt), 32'd0);
    check("basic_rearm_out_valid", 32'(out_valid), 32'd0);

    // Overflow on ACC_W=6: 4*31 = 124 -> 60 with ovf; then 4*1 = 4 without
    b_out_ready = 1'b1;
    exp_b.push_back({1'b1, 6'd60});
    for (int i = 0; i < 4; i++) send_b(1'b1, 4'hF);
    check("b_valid_after_ovf_group", 32'(b_out_valid), 32'd1);
    tick();
    exp_b.push_back({1'b0, 6'd4});
    for (int i = 0; i < 4; i++) send_b(1'b0, 4'd1);
    check("b_valid_after_second_group", 32'(b_out_valid), 32'd1);
    tick();

    // Backpressure with gaps: 1+2+3+4 = 10
    out_ready = 1'b0;
    exp_a.push_back({1'b0, 8'd10});
    send(1'b0, 4'd1);
    tick();
    check("gap_beat_cnt_1", 32'(beat_cnt), 32'd1);
    send(1'b0, 4'd2);
    tick(); tick();
    check("gap_beat_cnt_2", 32'(beat_cnt), 32'd2);
    send(1'b0, 4'd3);
    tick();
    check("gap_beat_cnt_3", 32'(beat_cnt), 32'd3);
    send(1'b0, 4'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_carry = 1'b0; in_sum = 4'hF;
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_out_acc_held", 32'(out_acc), 32'd10);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_beat_cnt_held", 32'(beat_cnt), 32'd4);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_popped", 32'(out_valid), 32'd0);

    // Clear mid-group: the beat alongside clear must be refused
    send(1'b0, 4'd7);
    send(1'b0, 4'd7);
    check("clr_beat_cnt_before", 32'(beat_cnt), 32'd2);
    clear = 1'b1; in_valid = 1'b1; in_carry = 1'b0; in_sum = 4'd7;
    #1;
    check("clr_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_beat_cnt_zero", 32'(beat_cnt), 32'd0);
    check("clr_acc_zero", 32'(out_acc), 32'd0);
    exp_a.push_back({1'b0, 8'd4});
    for (int i = 0; i < 4; i++) send(1'b0, 4'd1);
    tick();

    // Async reset while DONE
    out_ready = 1'b0;
    send(1'b0, 4'd3);
    send(1'b0, 4'd5);
    send(1'b1, 4'd0);
    send(1'b0, 4'd15);
    check("ar_done_valid", 32'(out_valid), 32'd1);
    check("ar_done_acc", 32'(out_acc), 32'h27);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_drops_async", 32'(out_valid), 32'd0);
    check("ar_in_ready_async", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("ar_post_in_ready", 32'(in_ready), 32'd1);
    check("ar_post_beat_cnt", 32'(beat_cnt), 32'd0);

    // Clear together with handshake in DONE: result dropped
    for (int i = 0; i < 4; i++) send(1'b0, 4'd2);
    check("cvh_done_acc", 32'(out_acc), 32'd8);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0;
    check("cvh_out_valid", 32'(out_valid), 32'd0);
    check("cvh_acc_zero", 32'(out_acc), 32'd0);
    check("cvh_ovf_zero", 32'(out_ovf), 32'd0);
    check("cvh_beat_cnt", 32'(beat_cnt), 32'd0);
    tick(); tick();

    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
